md5_hex_emitter: RTL and testbench
==================================

# md5_hex_emitter

Converts a finished 128-bit MD5 digest into the canonical 32-character lowercase ASCII hex string, one character per handshake, for the keyboard/display writer that places characters into video memory. It works in the opposite direction to the keyboard-to-message path. That path turns ASCII into message bytes for the MD5 core; this block turns the core's chaining words back into ASCII. It sits between the MD5 finalisation logic (digest source) and the display-memory character writer (ASCII sink).

## Interface
- APPEND_CR, default 1: after the 32nd hex character, emit 8'h0d (carriage return) as a 33rd character.
- GAP, default 0: idle cycles forced after each accepted character (ascii_valid low), 0..15.

- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- digest_valid  in  1  digest present on `digest`.
- digest  in  128  {A,B,C,D}: A in [127:96], B in [95:64], C in [63:32], D in [31:0].
- digest_ready  out  1  high only in IDLE; capture when digest_valid && digest_ready.
- ascii  out  8  current character.
- ascii_valid  out  1  character valid; held until accepted.
- ascii_ready  in  1  sink accepts when ascii_valid && ascii_ready.
- busy  out  1  high from capture until done.
- done  out  1  one-cycle pulse after the final character is accepted.

## Operation
- States: IDLE, EMIT, GAP_WAIT, TERM, FIN.
- IDLE:
  - digest_ready=1.
  - On capture: latch the 128-bit digest, set idx=0, go to EMIT.
- EMIT:
  - ascii_valid=1; ascii = hex(nibble(idx)).
  - On accept, if idx==31: go to TERM when APPEND_CR=1, otherwise go to FIN.
  - On accept, if idx<31: idx+1, then go to GAP_WAIT if GAP>0, otherwise stay in EMIT.
- GAP_WAIT: ascii_valid=0; count GAP cycles, then return to EMIT.
- TERM: ascii_valid=1, ascii=8'h0d; on accept, go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Nibble order follows the standard MD5 output byte order (little-endian within each word):
  - word w = idx[4:3] (0=A … 3=D);
  - byte b = idx[2:1], taken as word[8b+7:8b];
  - idx[0]=0 selects the high nibble, idx[0]=1 the low nibble.
- Hex map: 0–9 → 8'h30–8'h39; a–f → 8'h61–8'h66.
- idx is 5 bits, saturates at 31, and never wraps during a job.
- digest_valid outside IDLE is ignored; no capture and no queuing. The source must hold digest_valid until it sees digest_ready.
- The ascii value is stable while ascii_valid && !ascii_ready. No character is dropped or repeated.

## Timing
- Capture at edge k: busy=1 and ascii_valid=1 with the first character from edge k+1.
- Zero-stall throughput (GAP=0, ascii_ready tied high): one character per cycle.
  - 32 characters on cycles k+1..k+32.
  - CR on cycle k+33 when APPEND_CR=1.
  - done on the next cycle; digest_ready returns the cycle after done.
- GAP=N adds N idle cycles after every accepted hex character. No gap precedes TERM.
- Back-to-back jobs: a new capture is possible on the first IDLE cycle after done.
- Reset (synchronous, any state, including mid-string):
  - next cycle: IDLE, idx=0, ascii=8'h00, ascii_valid=0, busy=0, done=0, digest_ready=1;
  - no done pulse for the aborted job.
- reset and digest_valid in the same cycle: reset wins; nothing is captured.

## Configuration
- MD5_HEX_UPPER_EN:
  - defined: digits a–f map to 8'h41–8'h46 ('A'–'F');
  - undefined (default): lowercase 8'h61–8'h66.
  - No other behaviour changes.

## Structure
- Shared package md5_pkg:
  - state enum for the emitter;
  - ASCII_CR = 8'h0d;
  - MD5 IV constants (67452301, efcdab89, 98badcfe, 10325476), shared with the update path.
- Sub-module nibble2ascii: combinational 4-bit → 8-bit map. It honours MD5_HEX_UPPER_EN and is reusable by other hex displays.

## Test plan
- Empty-string digest:
  - Stimulus: A=d98c1dd4, B=04b2008f, C=980980e9, D=7e42f8ec; ascii_ready=1; GAP=0.
  - Required: character stream "d41d8cd98f00b204e9800998ecf8427e" then 8'h0d; done exactly 34 cycles after capture.
- Backpressure:
  - Stimulus: same digest; ascii_ready random 30% duty.
  - Required: identical 33-character sequence; ascii stable while not accepted; no duplicates.
- GAP=3, APPEND_CR=0:
  - Required: ascii_valid low for exactly 3 cycles between hex characters; 32 characters; done after the 32nd accept; no 8'h0d.
- Busy rejection:
  - Stimulus: a second digest_valid with digest 0xffff… during EMIT.
  - Required: ignored; output unchanged; after done, a fresh handshake emits 32 × 'f'.
- Mid-job reset:
  - Stimulus: assert reset at character 10.
  - Required: next cycle ascii_valid=0, busy=0, digest_ready=1; no done pulse; a following job is correct.
- MD5_HEX_UPPER_EN defined:
  - Stimulus: empty-string digest.
  - Required: "D41D8CD98F00B204E9800998ECF8427E".

Source files
------------

// File: rtl/md5_pkg.sv
// Shared MD5 definitions: emitter state encoding, ASCII constants, MD5 IV
// words (also used by the update path) and the digest nibble selector.
package md5_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EMIT     = 3'd1,
    ST_GAP_WAIT = 3'd2,
    ST_TERM     = 3'd3,
    ST_FIN      = 3'd4
  } emit_state_e;

  localparam logic [7:0] ASCII_CR  = 8'h0d;
  localparam logic [7:0] ASCII_NUL = 8'h00;

  localparam logic [4:0] LAST_IDX = 5'd31;

  localparam logic [31:0] MD5_IV_A = 32'h67452301;
  localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
  localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
  localparam logic [31:0] MD5_IV_D = 32'h10325476;

  // Pick the idx-th nibble of the digest in canonical MD5 print order:
  // words A..D in turn, bytes little-endian inside a word, high nibble first.
  function automatic logic [3:0] digest_nibble(input logic [127:0] dig,
                                               input logic [4:0]   idx);
    logic [31:0] word_v;
    logic [7:0]  byte_v;
    case (idx[4:3])
      2'd0:    word_v = dig[127:96];
      2'd1:    word_v = dig[95:64];
      2'd2:    word_v = dig[63:32];
      default: word_v = dig[31:0];
    endcase
    case (idx[2:1])
      2'd0:    byte_v = word_v[7:0];
      2'd1:    byte_v = word_v[15:8];
      2'd2:    byte_v = word_v[23:16];
      default: byte_v = word_v[31:24];
    endcase
    return idx[0] ? byte_v[3:0] : byte_v[7:4];
  endfunction

endpackage

// File: rtl/nibble2ascii.sv
// Combinational 4-bit value to ASCII hex digit.
// MD5_HEX_UPPER_EN: when defined, digits a-f become 'A'-'F'; default lowercase.
module nibble2ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

`ifdef MD5_HEX_UPPER_EN
  localparam logic [7:0] ALPHA_BASE = 8'h41;
`else
  localparam logic [7:0] ALPHA_BASE = 8'h61;
`endif

  // Digits 0-9 start at '0'; 10-15 start at the letter base.
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'd0, nibble};
    end else begin
      ascii = ALPHA_BASE + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/md5_hex_emitter.sv
// Streams a captured 128-bit MD5 digest as 32 ASCII hex characters (plus an
// optional trailing CR) over a valid/ready link to the display writer.
// Letter case follows MD5_HEX_UPPER_EN (see nibble2ascii).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and data stable until that edge; ready may
// change freely. digest_ready is high only while idle; ascii/ascii_valid are
// registered and remain stable until the sink accepts.
module md5_hex_emitter
  import md5_pkg::*;
#(
  parameter bit          APPEND_CR = 1'b1,
  parameter int unsigned GAP       = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         digest_valid,
  input  logic [127:0] digest,
  output logic         digest_ready,
  output logic [7:0]   ascii,
  output logic         ascii_valid,
  input  logic         ascii_ready,
  output logic         busy,
  output logic         done,
  output logic [2:0]   dbg_state
);

  localparam int unsigned GAP_M1   = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [3:0]  GAP_LOAD = GAP_M1[3:0];

  emit_state_e  state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic [3:0]   gap_cnt_q, gap_cnt_d;
  logic [127:0] digest_q, digest_d;
  logic [7:0]   ascii_q, ascii_d;
  logic         ascii_valid_q, ascii_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         digest_ready_q, digest_ready_d;

  logic [4:0]   idx_next;
  logic [127:0] nib_src;
  logic [4:0]   nib_idx;
  logic [3:0]   nib_val;
  logic [7:0]   hex_char;
  logic         accept;

  assign idx_next = (idx_q == LAST_IDX) ? LAST_IDX : idx_q + 5'd1;
  assign accept   = ascii_valid_q && ascii_ready;

  // Choose which nibble the next registered character comes from: the live
  // input at capture, the current index after a gap, otherwise the next index.
  always_comb begin
    nib_src = digest_q;
    nib_idx = idx_next;
    if (state_q == ST_IDLE) begin
      nib_src = digest;
      nib_idx = 5'd0;
    end else if (state_q == ST_GAP_WAIT) begin
      nib_idx = idx_q;
    end
  end

  assign nib_val = digest_nibble(nib_src, nib_idx);

  nibble2ascii u_hex (
    .nibble (nib_val),
    .ascii  (hex_char)
  );

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    gap_cnt_d      = gap_cnt_q;
    digest_d       = digest_q;
    ascii_d        = ascii_q;
    ascii_valid_d  = ascii_valid_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    digest_ready_d = digest_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (digest_valid && digest_ready_q) begin
          digest_d       = digest;
          idx_d          = 5'd0;
          ascii_d        = hex_char;
          ascii_valid_d  = 1'b1;
          busy_d         = 1'b1;
          digest_ready_d = 1'b0;
          state_d        = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            if (APPEND_CR) begin
              ascii_d = ASCII_CR;
              state_d = ST_TERM;
            end else begin
              ascii_valid_d = 1'b0;
              done_d        = 1'b1;
              state_d       = ST_FIN;
            end
          end else begin
            idx_d = idx_next;
            if (GAP > 0) begin
              ascii_valid_d = 1'b0;
              gap_cnt_d     = GAP_LOAD;
              state_d       = ST_GAP_WAIT;
            end else begin
              ascii_d = hex_char;
            end
          end
        end
      end
      ST_GAP_WAIT: begin
        if (gap_cnt_q == 4'd0) begin
          ascii_d       = hex_char;
          ascii_valid_d = 1'b1;
          state_d       = ST_EMIT;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      ST_TERM: begin
        if (accept) begin
          ascii_valid_d = 1'b0;
          done_d        = 1'b1;
          state_d       = ST_FIN;
        end
      end
      ST_FIN: begin
        busy_d         = 1'b0;
        digest_ready_d = 1'b1;
        state_d        = ST_IDLE;
      end
      default: begin
        ascii_valid_d  = 1'b0;
        busy_d         = 1'b0;
        digest_ready_d = 1'b1;
        state_d        = ST_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any job silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= 5'd0;
      gap_cnt_q      <= 4'd0;
      digest_q       <= '0;
      ascii_q        <= ASCII_NUL;
      ascii_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      digest_ready_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      gap_cnt_q      <= gap_cnt_d;
      digest_q       <= digest_d;
      ascii_q        <= ascii_d;
      ascii_valid_q  <= ascii_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      digest_ready_q <= digest_ready_d;
    end
  end

  assign digest_ready = digest_ready_q;
  assign ascii        = ascii_q;
  assign ascii_valid  = ascii_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_md5_hex_emitter.sv
// Bench for md5_hex_emitter: dut0 uses the default build (CR appended, no gap),
// dut1 uses APPEND_CR=0, GAP=3. Expected characters go into exp_q when a
// digest is offered and are popped as the sink accepts them.
module tb_md5_hex_emitter;

  logic         clk;
  logic         reset;

  logic         d0_dv, d0_dr, d0_av, d0_rdy, d0_busy, d0_done;
  logic [127:0] d0_digest;
  logic [7:0]   d0_ascii;
  logic [2:0]   d0_state;

  logic         d1_dv, d1_dr, d1_av, d1_rdy, d1_busy, d1_done;
  logic [127:0] d1_digest;
  logic [7:0]   d1_ascii;
  logic [2:0]   d1_state;

  logic [7:0]   exp_q[$];
  int           n_checks;
  int           n_errors;

  localparam logic [127:0] EMPTY_DIG = {32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec};
  localparam logic [127:0] ONES_DIG  = {128{1'b1}};

  md5_hex_emitter #(.APPEND_CR(1'b1), .GAP(0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .digest_valid (d0_dv),
    .digest       (d0_digest),
    .digest_ready (d0_dr),
    .ascii        (d0_ascii),
    .ascii_valid  (d0_av),
    .ascii_ready  (d0_rdy),
    .busy         (d0_busy),
    .done         (d0_done),
    .dbg_state    (d0_state)
  );

  md5_hex_emitter #(.APPEND_CR(1'b0), .GAP(3)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .digest_valid (d1_dv),
    .digest       (d1_digest),
    .digest_ready (d1_dr),
    .ascii        (d1_ascii),
    .ascii_valid  (d1_av),
    .ascii_ready  (d1_rdy),
    .busy         (d1_busy),
    .done         (d1_done),
    .dbg_state    (d1_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: canonical MD5 hex print order from the digest words.
  task automatic push_model(input logic [127:0] dig, input bit with_cr);
    string      hexd;
    logic [31:0] word_v;
    logic [7:0]  byte_v;
`ifdef MD5_HEX_UPPER_EN
    hexd = "0123456789ABCDEF";
`else
    hexd = "0123456789abcdef";
`endif
    for (int w = 0; w < 4; w++) begin
      word_v = dig[127 - 32*w -: 32];
      for (int b = 0; b < 4; b++) begin
        byte_v = word_v[8*b +: 8];
        exp_q.push_back(hexd[int'(byte_v[7:4])]);
        exp_q.push_back(hexd[int'(byte_v[3:0])]);
      end
    end
    if (with_cr) exp_q.push_back(8'h0d);
  endtask

  task automatic push_string(input string s, input bit with_cr);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (with_cr) exp_q.push_back(8'h0d);
  endtask

  // Driver: offer a digest to dut0 and return on the capture cycle.
  task automatic start0(input logic [127:0] dig);
    int t;
    @(negedge clk);
    d0_digest = dig;
    d0_dv     = 1'b1;
    t = 0;
    while (d0_dr !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (d0_dr !== 1'b1 || d0_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL start0_handshake: digest_ready=%b busy=%b, required 1/0", d0_dr, d0_busy);
    end
  endtask

  task automatic start1(input logic [127:0] dig);
    int t;
    @(negedge clk);
    d1_digest = dig;
    d1_dv     = 1'b1;
    t = 0;
    while (d1_dr !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (d1_dr !== 1'b1) begin
      n_errors++;
      $display("FAIL start1_handshake: digest_ready=%b, required 1", d1_dr);
    end
  endtask

  // Scoreboard for dut0: pops on each accept, checks hold-while-stalled,
  // done timing and queue drain. Optionally injects a rejected digest
  // mid-job, and optionally offers the next digest during the done cycle.
  task automatic drain0(input int pct, input int exp_done_cyc, input bit inject,
                        input bit chain, input logic [127:0] chain_dig);
    bit         pend;
    bit         saw_done;
    logic [7:0] pend_c;
    logic [7:0] e;
    pend     = 1'b0;
    saw_done = 1'b0;
    for (int cyc = 1; cyc <= 3000 && !saw_done; cyc++) begin
      @(negedge clk);
      d0_dv = 1'b0;
      if (inject && cyc >= 5 && cyc < 12) begin
        d0_dv     = 1'b1;
        d0_digest = ONES_DIG;
        n_checks++;
        if (d0_dr !== 1'b0) begin
          n_errors++;
          $display("FAIL busy_ready: digest_ready=%b during job, required 0", d0_dr);
        end
      end
      if (pend) begin
        n_checks++;
        if (d0_av !== 1'b1 || d0_ascii !== pend_c) begin
          n_errors++;
          $display("FAIL hold: valid=%b ascii=%h, required 1 %h", d0_av, d0_ascii, pend_c);
        end
      end
      if (d0_done === 1'b1) begin
        saw_done = 1'b1;
        n_checks++;
        if (exp_q.size() != 0 || d0_dr !== 1'b0 || d0_av !== 1'b0) begin
          n_errors++;
          $display("FAIL done_state: left=%0d ready=%b valid=%b, required 0 0 0",
                   exp_q.size(), d0_dr, d0_av);
        end
        if (exp_done_cyc > 0) begin
          n_checks++;
          if (cyc != exp_done_cyc) begin
            n_errors++;
            $display("FAIL done_cycle: got %0d, required %0d", cyc, exp_done_cyc);
          end
        end
        if (chain) begin
          d0_dv     = 1'b1;
          d0_digest = chain_dig;
          push_model(chain_dig, 1'b1);
        end
      end else if (d0_av === 1'b1) begin
        d0_rdy = ($urandom_range(0, 99) < pct);
        if (d0_rdy) begin
          pend = 1'b0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL extra_char: got %h, required none", d0_ascii);
          end else begin
            e = exp_q.pop_front();
            if (d0_ascii !== e) begin
              n_errors++;
              $display("FAIL char: got %h, required %h", d0_ascii, e);
            end
          end
        end else begin
          pend   = 1'b1;
          pend_c = d0_ascii;
        end
      end else begin
        pend = 1'b0;
      end
    end
    n_checks++;
    if (!saw_done) begin
      n_errors++;
      $display("FAIL drain0_timeout: done=0, required 1");
    end
    d0_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (d0_done !== 1'b0 || d0_dr !== 1'b1 || d0_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL after_done: done=%b ready=%b busy=%b, required 0 1 0", d0_done, d0_dr, d0_busy);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    d0_dv     = 1'b0;
    d1_dv     = 1'b0;
    d0_rdy    = 1'b1;
    d1_rdy    = 1'b1;
    d0_digest = '0;
    d1_digest = '0;
    repeat (2) @(negedge clk);
    d0_dv     = 1'b1;
    d0_digest = {4{$urandom()}};
    d1_dv     = 1'b1;
    d1_digest = {4{$urandom()}};
    @(negedge clk);
    n_checks++;
    if (d0_av !== 1'b0 || d0_busy !== 1'b0 || d0_done !== 1'b0 || d0_dr !== 1'b1 ||
        d0_ascii !== 8'h00 || d0_state !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_dut0: valid=%b busy=%b done=%b ready=%b ascii=%h state=%0d, required 0 0 0 1 00 0",
               d0_av, d0_busy, d0_done, d0_dr, d0_ascii, d0_state);
    end
    n_checks++;
    if (d1_av !== 1'b0 || d1_busy !== 1'b0 || d1_dr !== 1'b1 || d1_ascii !== 8'h00 || d1_state !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_dut1: valid=%b busy=%b ready=%b ascii=%h state=%0d, required 0 0 1 00 0",
               d1_av, d1_busy, d1_dr, d1_ascii, d1_state);
    end
    reset = 1'b0;
    d0_dv = 1'b0;
    d1_dv = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d0_busy !== 1'b0 || d1_busy !== 1'b0 || d0_av !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_wins: busy0=%b busy1=%b valid0=%b, required 0 0 0", d0_busy, d1_busy, d0_av);
    end
  endtask

  task automatic test_empty_digest();
    string lit;
`ifdef MD5_HEX_UPPER_EN
    lit = "D41D8CD98F00B204E9800998ECF8427E";
`else
    lit = "d41d8cd98f00b204e9800998ecf8427e";
`endif
    exp_q.delete();
    push_string(lit, 1'b1);
    start0(EMPTY_DIG);
    drain0(100, 34, 1'b0, 1'b0, '0);
  endtask

  task automatic test_backpressure();
    exp_q.delete();
    push_model(EMPTY_DIG, 1'b1);
    start0(EMPTY_DIG);
    drain0(30, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_busy_reject();
    string fs;
    fs = "ffffffffffffffffffffffffffffffff";
    exp_q.delete();
    push_model(EMPTY_DIG, 1'b1);
    start0(EMPTY_DIG);
    drain0(70, 0, 1'b1, 1'b0, '0);
    push_string(fs, 1'b1);
    start0(ONES_DIG);
    drain0(100, 34, 1'b0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] a;
    logic [127:0] b;
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_q.delete();
    push_model(a, 1'b1);
    start0(a);
    drain0(100, 34, 1'b0, 1'b1, b);
    drain0(60, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_mid_reset();
    logic [127:0] dig;
    logic [7:0]   e;
    int           accepted;
    bit           fired;
    dig = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_q.delete();
    push_model(dig, 1'b1);
    start0(dig);
    accepted = 0;
    fired    = 1'b0;
    for (int c = 1; c <= 200 && !fired; c++) begin
      @(negedge clk);
      d0_dv  = 1'b0;
      d0_rdy = 1'b1;
      if (d0_av === 1'b1) begin
        accepted++;
        e = exp_q.pop_front();
        n_checks++;
        if (d0_ascii !== e) begin
          n_errors++;
          $display("FAIL mid_char: got %h, required %h", d0_ascii, e);
        end
        if (accepted == 10) begin
          reset = 1'b1;
          fired = 1'b1;
        end
      end
    end
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (d0_av !== 1'b0 || d0_busy !== 1'b0 || d0_dr !== 1'b1 || d0_done !== 1'b0 || d0_ascii !== 8'h00) begin
      n_errors++;
      $display("FAIL mid_reset: valid=%b busy=%b ready=%b done=%b ascii=%h, required 0 0 1 0 00",
               d0_av, d0_busy, d0_dr, d0_done, d0_ascii);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_checks++;
      if (d0_done !== 1'b0 || d0_av !== 1'b0) begin
        n_errors++;
        $display("FAIL aborted_done: done=%b valid=%b, required 0 0", d0_done, d0_av);
      end
    end
    exp_q.delete();
    dig = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_model(dig, 1'b1);
    start0(dig);
    drain0(100, 34, 1'b0, 1'b0, '0);
  endtask

  // GAP=3, no CR: exactly three idle cycles between hex characters.
  task automatic test_gap();
    logic [127:0] dig;
    logic [7:0]   e;
    int           idle_run;
    int           accepted;
    bit           saw_done;
    dig = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_q.delete();
    push_model(dig, 1'b0);
    start1(dig);
    idle_run = 0;
    accepted = 0;
    saw_done = 1'b0;
    for (int cyc = 1; cyc <= 1000 && !saw_done; cyc++) begin
      @(negedge clk);
      d1_dv  = 1'b0;
      d1_rdy = 1'b1;
      if (d1_done === 1'b1) begin
        saw_done = 1'b1;
        n_checks++;
        if (cyc != 126 || accepted != 32 || exp_q.size() != 0) begin
          n_errors++;
          $display("FAIL gap_done: cycle=%0d chars=%0d left=%0d, required 126 32 0",
                   cyc, accepted, exp_q.size());
        end
      end else if (d1_av === 1'b1) begin
        if (accepted > 0) begin
          n_checks++;
          if (idle_run != 3) begin
            n_errors++;
            $display("FAIL gap_len: idle=%0d, required 3", idle_run);
          end
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL gap_extra: got %h, required none", d1_ascii);
        end else begin
          e = exp_q.pop_front();
          if (d1_ascii !== e) begin
            n_errors++;
            $display("FAIL gap_char: got %h, required %h", d1_ascii, e);
          end
        end
        accepted++;
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end
    n_checks++;
    if (!saw_done) begin
      n_errors++;
      $display("FAIL gap_timeout: done=0, required 1");
    end
    @(negedge clk);
    n_checks++;
    if (d1_done !== 1'b0 || d1_dr !== 1'b1 || d1_av !== 1'b0) begin
      n_errors++;
      $display("FAIL gap_after: done=%b ready=%b valid=%b, required 0 1 0", d1_done, d1_dr, d1_av);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_empty_digest();
    test_backpressure();
    test_busy_reject();
    test_back_to_back();
    test_mid_reset();
    test_gap();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
